apb_cmd_arbiter: RTL

Parametrised N-channel command arbiter in front of the APB command FIFO. It replaces the two-input write-first arbiter. Each channel presents read or write requests. The block selects one request per cycle using write-first filtering plus fixed or round-robin priority, and registers the selected command with its source ID. It holds the command under FIFO backpressure and returns a per-channel grant pulse.

---
 rtl/defines_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/apb_cmd_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/defines_pkg.sv
// Shared widths, command payload type and sizing helper for the APB command path.
package defines_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } arb_cmd_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational picker: first set bit of i_elig at or above i_ptr, wrapping.
module rr_picker
  import defines_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    w_j      = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_elig[w_j]) begin
        o_any         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// N-channel write-first command arbiter feeding the APB command FIFO.
// ARB_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module apb_cmd_arbiter
  import defines_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ADDR_W   = defines_pkg::ADDR_W,
  parameter int DATA_W   = defines_pkg::DATA_W,
  parameter int WR_FIRST = 1,
  localparam int IDW     = clog2_min1(N_CH),
  localparam int CMD_W   = IDW + 1 + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          we_i,
  input  logic [N_CH*ADDR_W-1:0]   addr_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  output logic [N_CH-1:0]          gnt_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [CMD_W-1:0]         fifo_data_o
);

  logic [N_CH-1:0]   w_wr_req;
  logic [N_CH-1:0]   w_elig;
  logic [N_CH-1:0]   w_onehot;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_ptr;
  logic              w_any;
  logic              w_load;
  logic              w_push;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              r_valid;
  logic [CMD_W-1:0]  r_cmd;

  assign w_wr_req = req_i & we_i;
  assign w_elig   = ((WR_FIRST != 0) && (|w_wr_req)) ? w_wr_req : req_i;

`ifdef ARB_RR_EN
  logic [IDW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= (w_idx == IDW'(N_CH - 1)) ? '0 : w_idx + IDW'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  rr_picker #(
    .N  (N_CH),
    .IW (IDW)
  ) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (w_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // The register accepts a new command only when empty or draining now.
  assign w_push = r_valid && !fifo_full_i;
  assign w_load = !rst && w_any && (!r_valid || !fifo_full_i);
  assign gnt_o  = w_load ? w_onehot : '0;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_onehot[c]) begin
        w_addr  = addr_i[c*ADDR_W +: ADDR_W];
        w_wdata = data_i[c*DATA_W +: DATA_W];
      end
    end
  end

  assign w_rw = |(w_onehot & we_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_cmd   <= {w_idx, w_rw, w_addr, (w_rw ? w_wdata : DATA_W'(0))};
    end else if (w_push) begin
      r_valid <= 1'b0;
    end
  end

  assign fifo_wr_en_o = r_valid;
  assign fifo_data_o  = r_cmd;

endmodule
